// File: rtl/scsa_pipe_adder_if.sv
// Handshake and data bundle for the speculative carry-select adder.
// The master side offers operands and consumes results; the slave side is the adder.
interface scsa_pipe_adder_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         err;
    logic         corrected;
    logic [15:0]  err_count;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, sum, cout, err, corrected, err_count
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, sum, cout, err, corrected, err_count
    );
endinterface

// File: rtl/scsa_pipe_adder.sv
// Speculative carry-select adder: blocks guess their carry-in from the previous block's
// carry-in-0 adder; mode=1 repairs mis-speculation one block per cycle.
module scsa_pipe_adder #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst,
    scsa_pipe_adder_if.slave bus
);
    localparam int M  = N / K;
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    if ((N % K) != 0 || M < 2) begin : g_bad_params
        $error("scsa_pipe_adder: N must be a multiple of K with N/K >= 2");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, FIX = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [K:0] blk_add(input logic [K-1:0] x, input logic [K-1:0] y,
                                           input logic ci);
        blk_add = {1'b0, x} + {1'b0, y} + {{K{1'b0}}, ci};
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;
    logic          corr_q, corr_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  spec_sum_s;
    logic          spec_cout_s;
    logic          err_s;
    logic          blk0_c_s;
    logic [K:0]    r0_s, r1_s, rsel_s, blk0_r_s, fix_r_s;
    logic          c0_prev_s;
    logic [N:0]    exact_s;

    // Speculative sum: block i's carry-in is the carry-in-0 carry-out of block i-1
    always_comb begin
        spec_sum_s  = {N{1'b0}};
        spec_cout_s = 1'b0;
        c0_prev_s   = 1'b0;
        r0_s        = {(K+1){1'b0}};
        r1_s        = {(K+1){1'b0}};
        rsel_s      = {(K+1){1'b0}};
        for (int i = 0; i < M; i++) begin
            r0_s   = blk_add(bus.a[i*K +: K], bus.b[i*K +: K], 1'b0);
            r1_s   = blk_add(bus.a[i*K +: K], bus.b[i*K +: K], 1'b1);
            rsel_s = c0_prev_s ? r1_s : r0_s;
            spec_sum_s[i*K +: K] = rsel_s[K-1:0];
            spec_cout_s = rsel_s[K];
            c0_prev_s   = r0_s[K];
        end
    end

    assign blk0_r_s = blk_add(bus.a[K-1:0], bus.b[K-1:0], 1'b0);
    assign blk0_c_s = blk0_r_s[K];
    assign exact_s  = {1'b0, bus.a} + {1'b0, bus.b};
    assign err_s    = (exact_s != {spec_cout_s, spec_sum_s});
    assign fix_r_s  = blk_add(a_q[idx_q*K +: K], b_q[idx_q*K +: K], carry_q);

    // Next-state and datapath update for the IDLE/FIX/DONE controller
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        err_d       = err_q;
        corr_d      = corr_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sum_d      = spec_sum_s;
                    cout_d     = spec_cout_s;
                    err_d      = err_s;
                    corr_d     = 1'b0;
                    a_d        = bus.a;
                    b_d        = bus.b;
                    in_ready_d = 1'b0;
                    if (err_s && (cnt_q != 16'hFFFF)) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (bus.mode && err_s) begin
                        state_d = FIX;
                        idx_d   = IW'(1);
                        carry_d = blk0_c_s;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FIX: begin
                // Recompute one block with the true carry, then ripple it onward
                sum_d[idx_q*K +: K] = fix_r_s[K-1:0];
                carry_d             = fix_r_s[K];
                if (idx_q == LAST_IDX) begin
                    cout_d      = fix_r_s[K];
                    corr_d      = 1'b1;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= {IW{1'b0}};
            carry_q     <= 1'b0;
            sum_q       <= {N{1'b0}};
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            corr_q      <= 1'b0;
            a_q         <= {N{1'b0}};
            b_q         <= {N{1'b0}};
            cnt_q       <= 16'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            corr_q      <= corr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;
    assign bus.corrected = corr_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_scsa_pipe_adder.sv
// Directed bench for scsa_pipe_adder (N=16, K=4) with hand-computed expectations.
module tb_scsa_pipe_adder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    scsa_pipe_adder_if #(.N(16)) bus ();

    scsa_pipe_adder #(.N(16), .K(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one transaction from IDLE, wait for the result, check it, then drain it
    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input logic [15:0] e_sum, input logic e_cout,
                           input logic e_err, input logic e_corr, input int e_lat,
                           input logic [15:0] e_cnt);
        int lat;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, ".latency"},   32'(lat),           32'(e_lat));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".sum"},       32'(bus.sum),       32'(e_sum));
        chk({tag, ".cout"},      32'(bus.cout),      32'(e_cout));
        chk({tag, ".err"},       32'(bus.err),       32'(e_err));
        chk({tag, ".corrected"}, 32'(bus.corrected), 32'(e_corr));
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'(e_cnt));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_ready"}, 32'(bus.in_ready),  32'd1);
        chk({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.sum",       32'(bus.sum),       32'd0);
        chk("rst.err_count", 32'(bus.err_count), 32'd0);
        step();
        rst = 1'b0;
        step();

        run_txn("exact_small", 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1, 16'd0);
        run_txn("approx_ff",   16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 16'd1);
        run_txn("fix_ff",      16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 4, 16'd2);
        run_txn("fix_ffff",    16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4, 16'd3);
        run_txn("approx_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'hFF00, 1'b0, 1'b1, 1'b0, 1, 16'd4);
        run_txn("fix_0fff",    16'h0FFF, 16'h0001, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b1, 4, 16'd5);
        run_txn("top_carry",   16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'd5);

        // Backpressure: hold out_ready low in DONE while offering a new input
        bus.a         = 16'h1234;
        bus.b         = 16'h4321;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.a = 16'h00FF;
        bus.b = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp.sum",       32'(bus.sum),       32'h5555);
            chk("bp.err",       32'(bus.err),       32'd0);
            chk("bp.err_count", 32'(bus.err_count), 32'd5);
            step();
        end
        chk("bp.held_sum", 32'(bus.sum), 32'h5555);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp.release_ready", 32'(bus.in_ready),  32'd1);
        chk("bp.release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp.release_cnt",   32'(bus.err_count), 32'd5);

        // Reset in the second FIX cycle discards the transaction
        bus.a        = 16'h00FF;
        bus.b        = 16'h0001;
        bus.mode     = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("fixrst.cnt_before", 32'(bus.err_count), 32'd6);
        chk("fixrst.in_fix",     32'(bus.in_ready),  32'd0);
        step();
        chk("fixrst.not_done",   32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("fixrst.sum",       32'(bus.sum),       32'd0);
        chk("fixrst.cout",      32'(bus.cout),      32'd0);
        chk("fixrst.err",       32'(bus.err),       32'd0);
        chk("fixrst.corrected", 32'(bus.corrected), 32'd0);
        chk("fixrst.err_count", 32'(bus.err_count), 32'd0);
        chk("fixrst.out_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("fixrst.in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        repeat (4) step();
        chk("fixrst.no_result", 32'(bus.out_valid), 32'd0);
        run_txn("after_rst", 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scsa_pipe_adder.md
SCSA_PIPE_ADDER -- requirements
Module: scsa_pipe_adder

Interface
REQ-001 Parameter N, default 16, operand width in bits.
REQ-002 Parameter K, default 4, sub-adder width; M = N/K sub-adders; N mod K = 0 and M >= 2 are mandatory, otherwise elaboration fails.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode are valid.
REQ-006 in_ready  output  1  block accepts operands; an input is accepted on an edge where in_valid && in_ready.
REQ-007 a, b  input  N  unsigned operands.
REQ-008 mode  input  1  0 = approximate result; 1 = exact result with error correction.
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result; handshake completes on an edge where out_valid && out_ready.
REQ-011 sum  output  N  result sum.
REQ-012 cout  output  1  result carry-out.
REQ-013 err  output  1  speculative result differed from exact a+b.
REQ-014 corrected  output  1  correction sequence ran for this result.
REQ-015 err_count  output  16  count of accepted transactions with err=1, saturating at 0xFFFF.

Function
REQ-016 Block 0 is a K-bit adder with carry-in 0; each block i (1..M-1) computes its K-bit sum twice, with carry-in 0 and with carry-in 1.
REQ-017 The speculative carry into block i (i >= 1) is the carry-out of block i-1's carry-in-0 adder; the speculative result selects each block's sum by that carry; speculative cout is the selected carry-out of block M-1.
REQ-018 err is 1 when the N+1-bit speculative {cout,sum} differs from the exact N+1-bit a+b, computed at acceptance in both modes.
REQ-019 The FSM has states IDLE, FIX and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-020 On acceptance in IDLE, the FSM registers the speculative sum, cout, err and the operands; next state is DONE if mode=0 or err=0, else FIX with block index 1 and true carry = carry-out of block 0.
REQ-021 In FIX, each cycle processes one block idx: sum[idx] is reselected by the true carry, the true carry becomes the selected carry-out, and idx increments; after block M-1, cout takes the final true carry, corrected is set and the next state is DONE.
REQ-022 Latency from the accepting edge T: out_valid rises at T+1 without correction and at T+M with correction.
REQ-023 In DONE, sum, cout, err and corrected remain stable until the out handshake; on out_ready=1 the next state is IDLE; in_valid is ignored while in FIX or DONE.
REQ-024 With mode=1, the final {cout,sum} equals exact a+b for all operands; with mode=0, it equals the speculative result.
REQ-025 err_count increments by 1 on the accepting edge when err=1 and holds at 0xFFFF.
REQ-026 Maximum throughput is one transaction per 2 cycles (IDLE then DONE with out_ready held at 1).

Reset
REQ-027 While rst=1, and immediately on its assertion, the FSM enters IDLE and sum=0, cout=0, err=0, corrected=0, out_valid=0, err_count=0; in_ready=1 once the FSM is in IDLE.
REQ-028 Asserting rst during FIX or DONE discards the transaction in flight, and no result is delivered.

Verification (N=16, K=4)
REQ-029 a=0x0001, b=0x0002, mode=1 -> sum=0x0003, cout=0, err=0, corrected=0, out_valid at T+1.
REQ-030 a=0x00FF, b=0x0001, mode=0 -> sum=0x0000, cout=0, err=1, corrected=0, out_valid at T+1, err_count=1.
REQ-031 a=0x00FF, b=0x0001, mode=1 -> sum=0x0100, cout=0, err=1, corrected=1, out_valid at T+4.
REQ-032 a=0xFFFF, b=0x0001, mode=1 -> sum=0x0000, cout=1, err=1 (speculative 0xFF00, cout=0), corrected=1.
REQ-033 Backpressure: out_ready=0 for 3 cycles in DONE -> outputs are stable, in_ready=0 and offered in_valid is not accepted; out_ready=1 -> IDLE on the next edge.
REQ-034 rst pulse during the second FIX cycle -> all outputs and err_count read 0 and in_ready=1; a new transaction afterwards completes normally.
